tvm_multibank_buffer: RTL and testbench
=======================================

Name: tvm_multibank_buffer

Overview:
- N-bank generalisation of the double buffer: a ring of NUM_BANKS equal windows between one producer and one consumer.
- Producer fills a bank by address, then closes it with write_advance. Consumer reads the oldest full bank by address, then frees it with read_advance.
- Adds a registered read path with a data-valid flag, a full-bank occupancy count, and sticky protocol-error flags.
- Sits between TVM-generated compute stages, replacing the fixed two-window buffer where deeper prefetch is needed.

Parameters:
- DATA_WIDTH, 8, word width.
- BANK_DEPTH, 16, words per bank (= read/write window = advance stride).
- NUM_BANKS, 4, number of banks; legal values >= 2, need not be a power of two.
- ADDR_WIDTH, 4, in-bank address width, clog2(BANK_DEPTH).
- CNT_WIDTH, 3, occupancy counter width, clog2(NUM_BANKS+1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- write_valid  in  1  write strobe.
- write_addr  in  ADDR_WIDTH  in-bank write address.
- write_data  in  DATA_WIDTH  write word.
- write_advance  in  1  close current write bank.
- write_ready  out  1  a free bank is open for writing.
- read_ready  in  1  read request.
- read_addr  in  ADDR_WIDTH  in-bank read address.
- read_advance  in  1  release current read bank.
- read_valid  out  1  at least one full bank is readable.
- read_data  out  DATA_WIDTH  registered read word.
- read_data_valid  out  1  read_data holds the word requested the previous cycle.
- status_counter  out  CNT_WIDTH  number of full banks.
- err_overflow  out  1  sticky: write_advance issued while write_ready=0.
- err_underflow  out  1  sticky: read_advance issued while read_valid=0.

Behaviour:
- State: wr_bank, rd_bank (0..NUM_BANKS-1, wrap by compare to NUM_BANKS-1, not by bit truncation); count (0..NUM_BANKS).
- Combinational: write_ready = (count != NUM_BANKS); read_valid = (count != 0); status_counter = count.
- Write: if write_valid && write_ready, mem[wr_bank*BANK_DEPTH + write_addr] <= write_data at the edge. A write with write_ready=0 is dropped with no flag.
- Write advance:
  - write_advance && write_ready -> wr_bank++ (wrap), count++.
  - A write in the same cycle as write_advance lands in the bank being closed.
  - write_advance && !write_ready -> ignored, err_overflow <= 1.
- Read:
  - If read_ready && read_valid: read_data <= mem[rd_bank*BANK_DEPTH + read_addr], read_data_valid <= 1 the next cycle (latency 1).
  - Otherwise read_data_valid <= 0 and read_data holds its previous value.
- Read advance:
  - read_advance && read_valid -> rd_bank++ (wrap), count--.
  - A read in the same cycle as read_advance uses the old rd_bank.
  - read_advance && !read_valid -> ignored, err_underflow <= 1.
- Simultaneous legal advances: both pointers move and count is unchanged.
- Full: at count==NUM_BANKS, write_advance is judged on the pre-edge count. It is rejected and flags overflow even if read_advance fires in the same cycle.
- Visibility: a bank closed at edge t is readable from cycle t+1; its data is visible because the final write also commits at edge t.
- No same-bank read/write conflict: when rd_bank==wr_bank, either count==0 (reads blocked) or count==NUM_BANKS (writes blocked).
- Reset (also mid-operation): wr_bank = rd_bank = count = 0, read_data = 0, read_data_valid = 0, err_* = 0. Memory contents are not reset; the buffer is empty after reset.

Decomposition:
- Package tvm_buffer_pkg holds:
  - helper function clog2;
  - bank-index wrap function next_bank(idx, NUM_BANKS);
  - default width constants.
- Sub-module tvm_bank_ram: simple dual-port RAM, depth NUM_BANKS*BANK_DEPTH, one write port, one registered read port with read enable.
- Top-level keeps the pointers, count, handshake and error logic.

Test Plan:
- Reset, then idle 5 cycles -> write_ready=1, read_valid=0, status_counter=0, read_data_valid=0, errors 0.
- Write data=addr+16*bank into 4 banks (16 words each, advance after each bank) -> status_counter 1,2,3,4; write_ready=0 after the 4th advance. A 5th write_advance -> err_overflow=1, count stays 4.
- Read all 4 banks, read_ready every cycle, advance at addr 15 -> read_data sequence 0..63 with read_data_valid one cycle after each request; status_counter counts down to 0, read_valid=0. An extra read_advance -> err_underflow=1.
- Steady streaming, write_advance and read_advance in the same cycle at count=2 -> count stays 2, both pointers wrap 3->0 correctly, data order preserved over 10 banks.
- Full with simultaneous write_advance and read_advance (count=4) -> count becomes 3, wr_bank unchanged, err_overflow=1.
- Assert rst mid-stream with count=3 -> next cycle count=0, read_valid=0, write_ready=1, err flags cleared; a refill then reads back new data correctly.

Source files
------------

// File: rtl/tvm_buffer_pkg.sv
// Shared sizing helpers and defaults for the TVM multi-bank ring buffer.
// Bank indices wrap by explicit compare so NUM_BANKS need not be a power of two.
package tvm_buffer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_BANK_DEPTH = 16;
    localparam int DEFAULT_NUM_BANKS  = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic int next_bank(input int idx, input int num_banks);
        return (idx == num_banks - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/tvm_bank_ram.sv
// Simple dual-port RAM backing all banks: one write port, one registered read
// port with enable. Only the output register is reset; contents are not.
module tvm_bank_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register holds its value when no read is requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/tvm_multibank_buffer.sv
// Ring of NUM_BANKS equal windows between one producer and one consumer;
// keeps bank pointers, full-bank count, handshakes and sticky protocol errors.
module tvm_multibank_buffer
    import tvm_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BANK_DEPTH = DEFAULT_BANK_DEPTH,
    parameter int NUM_BANKS  = DEFAULT_NUM_BANKS,
    parameter int ADDR_WIDTH = clog2(BANK_DEPTH),
    parameter int CNT_WIDTH  = clog2(NUM_BANKS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_valid,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_advance,
    output logic                  write_ready,
    input  logic                  read_ready,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  read_advance,
    output logic                  read_valid,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_data_valid,
    output logic [CNT_WIDTH-1:0]  status_counter,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam int BANK_WIDTH     = clog2(NUM_BANKS);
    localparam int MEM_DEPTH      = NUM_BANKS * BANK_DEPTH;
    localparam int MEM_ADDR_WIDTH = clog2(MEM_DEPTH);

    logic [BANK_WIDTH-1:0]     wr_bank_reg, wr_bank_next;
    logic [BANK_WIDTH-1:0]     rd_bank_reg, rd_bank_next;
    logic [CNT_WIDTH-1:0]      count_reg, count_next;
    logic                      read_data_valid_reg;
    logic                      err_overflow_reg, err_underflow_reg;
    logic                      wr_fire, rd_fire, wr_en, rd_en;
    logic [MEM_ADDR_WIDTH-1:0] wr_mem_addr, rd_mem_addr;

    assign write_ready    = (count_reg != CNT_WIDTH'(NUM_BANKS));
    assign read_valid     = (count_reg != '0);
    assign status_counter = count_reg;

    // Advances are judged on the pre-edge count, so a full buffer rejects
    // write_advance even when a read_advance frees a bank in the same cycle.
    assign wr_fire = write_advance && write_ready;
    assign rd_fire = read_advance && read_valid;
    assign wr_en   = write_valid && write_ready;
    assign rd_en   = read_ready && read_valid;

    assign wr_mem_addr = MEM_ADDR_WIDTH'(wr_bank_reg) * MEM_ADDR_WIDTH'(BANK_DEPTH)
                       + MEM_ADDR_WIDTH'(write_addr);
    assign rd_mem_addr = MEM_ADDR_WIDTH'(rd_bank_reg) * MEM_ADDR_WIDTH'(BANK_DEPTH)
                       + MEM_ADDR_WIDTH'(read_addr);

    always_comb begin
        wr_bank_next = wr_bank_reg;
        rd_bank_next = rd_bank_reg;
        count_next   = count_reg;
        if (wr_fire) begin
            wr_bank_next = BANK_WIDTH'(next_bank(int'(wr_bank_reg), NUM_BANKS));
        end
        if (rd_fire) begin
            rd_bank_next = BANK_WIDTH'(next_bank(int'(rd_bank_reg), NUM_BANKS));
        end
        if (wr_fire && !rd_fire) begin
            count_next = count_reg + CNT_WIDTH'(1);
        end else if (rd_fire && !wr_fire) begin
            count_next = count_reg - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_reg         <= '0;
            rd_bank_reg         <= '0;
            count_reg           <= '0;
            read_data_valid_reg <= 1'b0;
            err_overflow_reg    <= 1'b0;
            err_underflow_reg   <= 1'b0;
        end else begin
            wr_bank_reg         <= wr_bank_next;
            rd_bank_reg         <= rd_bank_next;
            count_reg           <= count_next;
            read_data_valid_reg <= rd_en;
            if (write_advance && !write_ready) begin
                err_overflow_reg <= 1'b1;
            end
            if (read_advance && !read_valid) begin
                err_underflow_reg <= 1'b1;
            end
        end
    end

    assign read_data_valid = read_data_valid_reg;
    assign err_overflow    = err_overflow_reg;
    assign err_underflow   = err_underflow_reg;

    tvm_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_bank_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_mem_addr),
        .wr_data (write_data),
        .rd_en   (rd_en),
        .rd_addr (rd_mem_addr),
        .rd_data (read_data)
    );

endmodule

// File: tb/tb_tvm_multibank_buffer.sv
// Directed plus randomized bench for tvm_multibank_buffer, checked against a
// queue-of-full-banks reference model.
module tb_tvm_multibank_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write_valid = 1'b0;
    logic [3:0] write_addr = '0;
    logic [7:0] write_data = '0;
    logic       write_advance = 1'b0;
    logic       write_ready;
    logic       read_ready = 1'b0;
    logic [3:0] read_addr = '0;
    logic       read_advance = 1'b0;
    logic       read_valid;
    logic [7:0] read_data;
    logic       read_data_valid;
    logic [2:0] status_counter;
    logic       err_overflow;
    logic       err_underflow;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO of closed banks plus the bank being filled.
    logic [127:0] m_q[$];
    logic [127:0] m_cur = '0;
    logic [7:0]   m_rd = '0;
    logic         m_rdv = 1'b0;
    logic         m_ov = 1'b0;
    logic         m_un = 1'b0;

    always #5 clk = ~clk;

    tvm_multibank_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .write_valid     (write_valid),
        .write_addr      (write_addr),
        .write_data      (write_data),
        .write_advance   (write_advance),
        .write_ready     (write_ready),
        .read_ready      (read_ready),
        .read_addr       (read_addr),
        .read_advance    (read_advance),
        .read_valid      (read_valid),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .status_counter  (status_counter),
        .err_overflow    (err_overflow),
        .err_underflow   (err_underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic wv, input logic [3:0] wa,
                        input logic [7:0] wd, input logic wadv, input logic rr,
                        input logic [3:0] ra, input logic radv);
        bit           wr_rdy, rd_vld;
        logic [127:0] front;
        rst = r; write_valid = wv; write_addr = wa; write_data = wd;
        write_advance = wadv; read_ready = rr; read_addr = ra; read_advance = radv;
        wr_rdy = (m_q.size() != 4);
        rd_vld = (m_q.size() != 0);
        if (r) begin
            m_q.delete();
            m_rd = '0; m_rdv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        end else begin
            if (wv && wr_rdy) m_cur[wa*8 +: 8] = wd;
            if (rr && rd_vld) begin
                front = m_q[0];
                m_rd  = front[ra*8 +: 8];
                m_rdv = 1'b1;
            end else begin
                m_rdv = 1'b0;
            end
            if (wadv && !wr_rdy) m_ov = 1'b1;
            if (radv && !rd_vld) m_un = 1'b1;
            if (radv && rd_vld) void'(m_q.pop_front());
            if (wadv && wr_rdy) m_q.push_back(m_cur);
        end
        @(posedge clk);
        #1;
        $display("step rst=%0b wv=%0b wa=%0d wadv=%0b rr=%0b ra=%0d radv=%0b -> cnt=%0d rdv=%0b rd=%0h",
                 r, wv, wa, wadv, rr, ra, radv, status_counter, read_data_valid, read_data);
        check("read_data_valid", 32'(read_data_valid), 32'(m_rdv));
        check("read_data", 32'(read_data), 32'(m_rd));
        check("status_counter", 32'(status_counter), 32'(m_q.size()));
        check("write_ready", 32'(write_ready), 32'(m_q.size() != 4));
        check("read_valid", 32'(read_valid), 32'(m_q.size() != 0));
        check("err_overflow", 32'(err_overflow), 32'(m_ov));
        check("err_underflow", 32'(err_underflow), 32'(m_un));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic write_bank_rand();
        for (int a = 0; a < 16; a++)
            step(1'b0, 1'b1, 4'(a), 8'($urandom), a == 15, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic read_bank();
        for (int a = 0; a < 16; a++)
            step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 4'(a), a == 15);
    endtask

    int         p;
    logic       rv, wv, wadv, rr, radv, rdy;
    logic [3:0] ra;

    initial begin
        // Reset, then idle
        step(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) idle();

        // Fill four banks with addr+16*bank, last write shares the advance cycle
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 16; a++)
                step(1'b0, 1'b1, 4'(a), 8'(a + 16 * b), a == 15, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Drain all four banks, then an extra read_advance
        for (int b = 0; b < 4; b++) read_bank();
        idle();
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b1);

        // Streaming at count=2 with simultaneous advances over 10 banks
        write_bank_rand();
        write_bank_rand();
        for (int k = 0; k < 10; k++)
            for (int a = 0; a < 16; a++)
                step(1'b0, 1'b1, 4'(a), 8'($urandom), a == 15, 1'b1, 4'(a), a == 15);

        // Full with simultaneous advances: write rejected, read accepted
        write_bank_rand();
        write_bank_rand();
        step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd0, 1'b1);
        write_bank_rand();
        read_bank();

        // Mid-stream reset at count=3, then refill and read back
        step(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        write_bank_rand();
        write_bank_rand();
        read_bank();
        read_bank();
        idle();

        // Randomized traffic; the producer always writes whole banks
        p = 0;
        for (int i = 0; i < 2000; i++) begin
            rv = ($urandom_range(0, 599) == 0);
            wv = 1'b0; wadv = 1'b0;
            if (p < 16 && $urandom_range(0, 3) != 0) begin
                wv   = 1'b1;
                wadv = (p == 15) && ($urandom_range(0, 1) == 1);
            end else if (p == 16) begin
                wadv = ($urandom_range(0, 2) != 0);
            end
            rr   = ($urandom_range(0, 1) == 1);
            ra   = 4'($urandom_range(0, 15));
            radv = ($urandom_range(0, 11) == 0);
            rdy  = (m_q.size() != 4);
            step(rv, wv, 4'(p), 8'($urandom), wadv, rr, ra, radv);
            if (rv) begin
                p = 0;
            end else if (rdy) begin
                if (wv) p++;
                if (wadv) p = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
